// File: rtl/loader_defs.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encodings, word geometry and a small state-decode helper.
package loader_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  localparam int BYTES_PER_WORD = 4;

  // A new load may only be launched from a quiescent state.
  function automatic logic start_allowed(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; the first byte of a
// word ends up in [31:24]. WordDone flags the cycle the 4th byte is taken.
module byte_packer
  import loader_defs::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clear,
  input  logic [7:0]  ByteIn,
  input  logic        Accept,
  output logic [31:0] Word,
  output logic        WordDone
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  count_q, count_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    count_d = count_q;
    shift_d = shift_q;
    if (Clear) begin
      count_d = '0;
    end else if (Accept) begin
      count_d = count_q + 2'd1;
      shift_d = {shift_q[23:0], ByteIn};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  // After the 4th shift the register itself holds the finished word.
  assign Word     = shift_q;
  assign WordDone = Accept && !Clear && (count_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory write port: streams bytes into
// words at consecutive addresses and holds the core in reset until done.
module imem_loader
  import loader_defs::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [LEN_WIDTH-1:0] LoadLen,
  input  logic [7:0]           ByteIn,
  input  logic                 ByteValid,
  output logic                 ByteReady,
  output logic                 ImemWrite,
  output logic [31:0]          ImemAddr,
  output logic [31:0]          ImemWriteData,
  output logic                 CpuReset,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [31:0]          Checksum
);

  localparam logic [LEN_WIDTH-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]  IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           csum_q, csum_d;

  logic        packer_clear;
  logic        byte_accept;
  logic        word_done;
  logic [31:0] packed_word;

  assign byte_accept = ByteValid && (state_q == ST_COLLECT);

  byte_packer u_packer (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (packer_clear),
    .ByteIn   (ByteIn),
    .Accept   (byte_accept),
    .Word     (packed_word),
    .WordDone (word_done)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    index_d      = index_q;
    addr_d       = addr_q;
    csum_d       = csum_q;
    packer_clear = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start && start_allowed(state_q)) begin
          len_d        = LoadLen;
          index_d      = '0;
          csum_d       = '0;
          packer_clear = 1'b1;
          if (LoadLen == '0)           state_d = ST_DONE;
          else if (LoadLen > MAX_WORDS) state_d = ST_ERROR;
          else                          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Address is captured here so it stays put through DONE.
        if (word_done) begin
          addr_d  = index_q[ADDR_WIDTH-1:0];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        csum_d  = csum_q ^ packed_word;
        index_d = index_q + IDX_ONE;
        state_d = ((index_q + IDX_ONE) == len_q) ? ST_DONE : ST_COLLECT;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      index_q <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
    end
  end

  assign ByteReady     = (state_q == ST_COLLECT);
  assign ImemWrite     = (state_q == ST_WRITE);
  assign Busy          = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign Done          = (state_q == ST_DONE);
  assign Error         = (state_q == ST_ERROR);
  assign CpuReset      = (state_q != ST_DONE);
  assign ImemAddr      = {{(30 - ADDR_WIDTH){1'b0}}, addr_q, 2'b00};
  assign ImemWriteData = packed_word;
  assign Checksum      = csum_q;

  a_write_single_cycle: assert property (@(posedge Clk) disable iff (Reset)
    ImemWrite |=> !ImemWrite);
  a_state_legal: assert property (@(posedge Clk) disable iff (Reset)
    state_q <= ST_ERROR);

endmodule
